// File: rtl/updi_phy_arbiter.sv
// Two-client arbiter that hands one updi_phy instance to one requester at a time.
// A handover waits for the double break to finish, drains stale RX bytes and then
// holds the line idle for GAP_CLKS cycles before the next grant.
module updi_phy_arbiter #(
    parameter int unsigned GAP_CLKS          = 5000,
    parameter int unsigned HOLD_TIMEOUT_CLKS = 0,
    parameter int unsigned CNT_BITS          = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic [1:0]  revoked,
    input  logic [15:0] cl_tx_data,
    input  logic [1:0]  cl_tx_wr_en,
    output logic [1:0]  cl_tx_full,
    output logic [7:0]  cl_rx_data,
    input  logic [1:0]  cl_rx_rd_en,
    output logic [1:0]  cl_rx_empty,
    input  logic [1:0]  cl_dbl_start,
    output logic [1:0]  cl_dbl_busy,
    output logic [1:0]  cl_dbl_done,
    output logic [1:0]  cl_phy_error,
    output logic [7:0]  uart_tx_fifo_data_in,
    output logic        uart_tx_fifo_wr_en,
    input  logic        uart_tx_fifo_full,
    input  logic [7:0]  uart_rx_fifo_data_out,
    output logic        uart_rx_fifo_rd_en,
    input  logic        uart_rx_fifo_empty,
    output logic        double_break_start,
    input  logic        double_break_busy,
    input  logic        double_break_done,
    input  logic        phy_error
);

    typedef enum logic [2:0] {
        StIdle,
        StOwn0,
        StOwn1,
        StRelease,
        StFlush,
        StGap
    } state_e;

    localparam logic [CNT_BITS-1:0] GapLast  = CNT_BITS'(GAP_CLKS - 1);
    localparam logic [CNT_BITS-1:0] HoldLast = CNT_BITS'(HOLD_TIMEOUT_CLKS - 1);
    localparam bit                  HoldEn   = (HOLD_TIMEOUT_CLKS != 0);

    state_e              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          revoked_q, revoked_d;
    logic                rr_last_q, rr_last_d;
    // Shared by the hold timer (OWNn) and the guard gap (GAP); never live in both.
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                own_idx;

    assign own_idx = (state_q == StOwn1);

    // Next-state logic: grant, hold/revoke, and the release -> flush -> gap handover.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        revoked_d = 2'b00;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        case (state_q)
            StIdle: begin
                // Client 0 wins when alone or when client 1 was served last.
                if (req[0] && (!req[1] || rr_last_q)) begin
                    state_d   = StOwn0;
                    gnt_d     = 2'b01;
                    rr_last_d = 1'b0;
                    cnt_d     = '0;
                end else if (req[1]) begin
                    state_d   = StOwn1;
                    gnt_d     = 2'b10;
                    rr_last_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            StOwn0, StOwn1: begin
                if (!req[own_idx]) begin
                    state_d = StRelease;
                    gnt_d   = 2'b00;
                end else if (HoldEn && (cnt_q == HoldLast)) begin
                    state_d   = StRelease;
                    gnt_d     = 2'b00;
                    revoked_d = own_idx ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            StRelease: begin
                if (!double_break_busy) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (uart_rx_fifo_empty) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State, grant and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= 2'b00;
            revoked_q <= 2'b00;
            rr_last_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            revoked_q <= revoked_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign revoked = revoked_q;

    // Routing follows the registered grant; a non-owner sees a full, empty, quiet PHY.
    always_comb begin
        uart_tx_fifo_data_in = 8'h00;
        if (gnt_q[1]) begin
            uart_tx_fifo_data_in = cl_tx_data[15:8];
        end else if (gnt_q[0]) begin
            uart_tx_fifo_data_in = cl_tx_data[7:0];
        end
        uart_tx_fifo_wr_en = |(gnt_q & cl_tx_wr_en);
        uart_rx_fifo_rd_en = (|(gnt_q & cl_rx_rd_en)) ||
                             ((state_q == StFlush) && !uart_rx_fifo_empty);
        double_break_start = |(gnt_q & cl_dbl_start);
        cl_rx_data         = (gnt_q != 2'b00) ? uart_rx_fifo_data_out : 8'h00;
        for (int i = 0; i < 2; i++) begin
            cl_tx_full[i]   = gnt_q[i] ? uart_tx_fifo_full : 1'b1;
            cl_rx_empty[i]  = gnt_q[i] ? uart_rx_fifo_empty : 1'b1;
            cl_dbl_busy[i]  = gnt_q[i] & double_break_busy;
            cl_dbl_done[i]  = gnt_q[i] & double_break_done;
            cl_phy_error[i] = gnt_q[i] & phy_error;
        end
    end

endmodule

// File: tb/tb_updi_phy_arbiter.sv
// Self-checking bench for updi_phy_arbiter: vector table, directed handover
// sequences and a randomized run, all checked every cycle against a reference model.
module tb_updi_phy_arbiter;

    localparam int unsigned GAP  = 8;
    localparam int unsigned HOLD = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  gnt, revoked;
    logic [15:0] cl_tx_data;
    logic [1:0]  cl_tx_wr_en, cl_tx_full;
    logic [7:0]  cl_rx_data;
    logic [1:0]  cl_rx_rd_en, cl_rx_empty;
    logic [1:0]  cl_dbl_start, cl_dbl_busy, cl_dbl_done, cl_phy_error;
    logic [7:0]  uart_tx_fifo_data_in;
    logic        uart_tx_fifo_wr_en, uart_tx_fifo_full;
    logic [7:0]  uart_rx_fifo_data_out;
    logic        uart_rx_fifo_rd_en, uart_rx_fifo_empty;
    logic        double_break_start, double_break_busy, double_break_done, phy_error;

    updi_phy_arbiter #(
        .GAP_CLKS         (GAP),
        .HOLD_TIMEOUT_CLKS(HOLD),
        .CNT_BITS         (32)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req                  (req),
        .gnt                  (gnt),
        .revoked              (revoked),
        .cl_tx_data           (cl_tx_data),
        .cl_tx_wr_en          (cl_tx_wr_en),
        .cl_tx_full           (cl_tx_full),
        .cl_rx_data           (cl_rx_data),
        .cl_rx_rd_en          (cl_rx_rd_en),
        .cl_rx_empty          (cl_rx_empty),
        .cl_dbl_start         (cl_dbl_start),
        .cl_dbl_busy          (cl_dbl_busy),
        .cl_dbl_done          (cl_dbl_done),
        .cl_phy_error         (cl_phy_error),
        .uart_tx_fifo_data_in (uart_tx_fifo_data_in),
        .uart_tx_fifo_wr_en   (uart_tx_fifo_wr_en),
        .uart_tx_fifo_full    (uart_tx_fifo_full),
        .uart_rx_fifo_data_out(uart_rx_fifo_data_out),
        .uart_rx_fifo_rd_en   (uart_rx_fifo_rd_en),
        .uart_rx_fifo_empty   (uart_rx_fifo_empty),
        .double_break_start   (double_break_start),
        .double_break_busy    (double_break_busy),
        .double_break_done    (double_break_done),
        .phy_error            (phy_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rx_cnt  = 0;   // bytes sitting in the modelled PHY RX FIFO

    // Reference model: who owns the PHY and how far a handover has progressed.
    int         m_owner;     // -1 = nobody
    int         m_phase;     // 0 free, 1 waiting for break idle, 2 draining RX, 3 guard gap
    int         m_held;      // cycles owned so far
    int         m_gap_left;
    int         m_last;      // client granted most recently
    logic [1:0] m_rev;

    // Outputs captured mid-cycle
    logic [1:0] s_gnt, s_rev, s_txf, s_rxe;
    logic       s_wr, s_rd, s_ds;
    logic [7:0] s_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_phase = 0;
        m_held  = 0;
        m_last  = 1;
        m_rev   = 2'b00;
    endtask

    // Advance the model across one clock edge using the inputs present now.
    task automatic model_step();
        m_rev = 2'b00;
        if (rst) begin
            model_reset();
        end else if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_phase = 1;
            end else if (HOLD != 0 && m_held + 1 >= HOLD) begin
                m_rev[m_owner] = 1'b1;
                m_owner = -1;
                m_phase = 1;
            end else begin
                m_held++;
            end
        end else begin
            case (m_phase)
                1: if (!double_break_busy) m_phase = 2;
                2: if (uart_rx_fifo_empty) begin
                    m_phase    = 3;
                    m_gap_left = GAP;
                end
                3: begin
                    m_gap_left--;
                    if (m_gap_left == 0) m_phase = 0;
                end
                default: if (req != 2'b00) begin
                    if (req == 2'b11) m_owner = 1 - m_last;
                    else              m_owner = req[1] ? 1 : 0;
                    m_last = m_owner;
                    m_held = 0;
                end
            endcase
        end
    endtask

    // One clock: compare all outputs against the model, advance model and RX FIFO.
    task automatic cycle();
        logic [1:0] eg, etf, ere, edb, edd, epe;
        logic       ew, erd, eds;
        logic [7:0] ed, erxd, ad, arxd;
        logic [32:0] expv, actv;
        @(negedge clk);
        eg = 2'b00;
        if (m_owner == 0) eg = 2'b01;
        if (m_owner == 1) eg = 2'b10;
        ew  = |(eg & cl_tx_wr_en);
        eds = |(eg & cl_dbl_start);
        erd = (|(eg & cl_rx_rd_en)) || (m_owner < 0 && m_phase == 2 && !uart_rx_fifo_empty);
        etf = 2'b11; ere = 2'b11; edb = 2'b00; edd = 2'b00; epe = 2'b00;
        if (m_owner >= 0) begin
            etf[m_owner] = uart_tx_fifo_full;
            ere[m_owner] = uart_rx_fifo_empty;
            edb[m_owner] = double_break_busy;
            edd[m_owner] = double_break_done;
            epe[m_owner] = phy_error;
        end
        ed   = ew ? ((m_owner == 1) ? cl_tx_data[15:8] : cl_tx_data[7:0]) : 8'h00;
        ad   = ew ? uart_tx_fifo_data_in : 8'h00;
        erxd = (m_owner >= 0) ? uart_rx_fifo_data_out : 8'h00;
        arxd = (m_owner >= 0) ? cl_rx_data : 8'h00;
        expv = {eg, m_rev, ew, ed, erd, eds, etf, ere, erxd, edb, edd, epe};
        actv = {gnt, revoked, uart_tx_fifo_wr_en, ad, uart_rx_fifo_rd_en, double_break_start,
                cl_tx_full, cl_rx_empty, arxd, cl_dbl_busy, cl_dbl_done, cl_phy_error};
        n_tests++;
        if (actv !== expv) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t: got %h expected %h", $time, actv, expv);
        end
        s_gnt = gnt; s_rev = revoked; s_wr = uart_tx_fifo_wr_en; s_data = uart_tx_fifo_data_in;
        s_rd = uart_rx_fifo_rd_en; s_ds = double_break_start; s_txf = cl_tx_full;
        s_rxe = cl_rx_empty;
        model_step();
        if (s_rd && rx_cnt > 0) rx_cnt--;
        @(posedge clk);
        #1;
        uart_rx_fifo_empty    = (rx_cnt == 0);
        uart_rx_fifo_data_out = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 2'b00; cl_tx_data = 16'h0; cl_tx_wr_en = 2'b00; cl_rx_rd_en = 2'b00;
        cl_dbl_start = 2'b00; uart_tx_fifo_full = 1'b0; double_break_busy = 1'b0;
        double_break_done = 1'b0; phy_error = 1'b0; rx_cnt = 0; uart_rx_fifo_empty = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [15:0] data;
        logic [1:0]  e_gnt;
        logic        e_wr;
        logic [7:0]  e_data;
        logic [1:0]  e_txf;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int         cnt, bad, rds, hold, revs;
        bit         seen;
        logic [1:0] rq;

        tbl[0] = '{2'b01, 2'b00, 16'h0000, 2'b00, 1'b0, 8'h00, 2'b11};
        tbl[1] = '{2'b01, 2'b01, 16'hAA55, 2'b01, 1'b1, 8'h55, 2'b10};
        tbl[2] = '{2'b01, 2'b10, 16'h3355, 2'b01, 1'b0, 8'h00, 2'b10};
        tbl[3] = '{2'b01, 2'b11, 16'hAA55, 2'b01, 1'b1, 8'h55, 2'b10};
        tbl[4] = '{2'b00, 2'b01, 16'h0077, 2'b01, 1'b1, 8'h77, 2'b10};
        tbl[5] = '{2'b00, 2'b01, 16'h0011, 2'b00, 1'b0, 8'h00, 2'b11};

        model_reset();
        uart_rx_fifo_data_out = 8'h00;
        do_reset();

        // Reset state
        cycle();
        check("reset_state", {s_gnt, s_rev, s_wr, s_rd, s_ds, s_txf, s_rxe},
              {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11});

        // Vector table: grant latency, owner-only TX routing
        for (int i = 0; i < 6; i++) begin
            req = tbl[i].req; cl_tx_wr_en = tbl[i].wr; cl_tx_data = tbl[i].data;
            cycle();
            check($sformatf("vec%0d", i), {s_gnt, s_wr, s_wr ? s_data : 8'h00, s_txf},
                  {tbl[i].e_gnt, tbl[i].e_wr, tbl[i].e_data, tbl[i].e_txf});
        end
        cl_tx_wr_en = 2'b00;
        for (int i = 0; i < 14; i++) cycle();

        // Simultaneous requests after reset, then handover timing
        do_reset();
        req = 2'b11;
        cycle();
        check("both_req_latency", s_gnt, 2'b00);
        cycle();
        check("both_req_client0_first", s_gnt, 2'b01);
        cycle();
        req = 2'b10;
        cycle();
        cnt = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            if (s_gnt == 2'b10) seen = 1; else cnt++;
        end
        // release + flush + GAP gap cycles + idle
        check("handover_gap_cycles", cnt, 3 + GAP);

        // Release held by busy double break, then RX flush of 3 bytes
        rx_cnt = 3; uart_rx_fifo_empty = 1'b0;
        cycle();
        req = 2'b00; double_break_busy = 1'b1;
        cycle();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_gnt != 2'b00 || s_rd) bad++;
        end
        check("busy_no_grant_no_rd", bad, 0);
        check("rx_bytes_kept_while_busy", rx_cnt, 3);
        double_break_busy = 1'b0; req = 2'b01;
        rds = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            if (s_gnt == 2'b01) seen = 1;
            else if (s_rd) rds++;
        end
        check("flush_rd_cycles", rds, 3);
        check("next_owner_granted", seen, 1);
        check("next_owner_rx_empty", s_rxe[0], 1'b1);

        // Hold timeout on client 1 with client 0 pending
        req = 2'b10; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            if (s_gnt == 2'b10) seen = 1;
        end
        check("client1_granted", seen, 1);
        req = 2'b11; hold = 1; revs = 0;
        for (int i = 0; i < 150; i++) begin
            cycle();
            if (s_rev != 2'b00) revs++;
            if (s_gnt != 2'b10) break;
            hold++;
        end
        check("hold_cycles", hold, HOLD);
        check("revoke_pulse", s_rev, 2'b10);
        cycle();
        check("revoke_one_cycle", s_rev, 2'b00);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            if (s_gnt == 2'b01) seen = 1;
        end
        check("pending_client0_after_revoke", seen, 1);

        // Reset mid-OWN1 with a TX write in flight
        req = 2'b10; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            if (s_gnt == 2'b10) seen = 1;
        end
        cl_tx_wr_en = 2'b10; cl_tx_data = 16'hC300; rst = 1'b1;
        cycle();
        check("wr_before_reset", {s_wr, s_data}, {1'b1, 8'hC3});
        rst = 1'b0; req = 2'b11;
        cycle();
        check("reset_clears_gnt_wr", {s_gnt, s_wr}, {2'b00, 1'b0});
        cl_tx_wr_en = 2'b00;
        cycle();
        check("rr_after_reset", s_gnt, 2'b01);

        // Randomized traffic against the model
        rq = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) rq[0] = ~rq[0];
            if ($urandom_range(0, 39) == 0) rq[1] = ~rq[1];
            req               = rq;
            rst               = ($urandom_range(0, 499) == 0);
            cl_tx_data        = 16'($urandom);
            cl_tx_wr_en       = 2'($urandom);
            cl_rx_rd_en       = 2'($urandom);
            cl_dbl_start      = 2'($urandom);
            uart_tx_fifo_full = ($urandom_range(0, 3) == 0);
            double_break_done = 1'($urandom);
            phy_error         = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) double_break_busy = ~double_break_busy;
            if ($urandom_range(0, 15) == 0 && rx_cnt < 6) begin
                rx_cnt += $urandom_range(1, 3);
                uart_rx_fifo_empty = 1'b0;
            end
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
